lfsr_gen: RTL

- Parametrised Fibonacci LFSR pseudo-random generator. It replaces the fixed 4-bit count-to-pattern lookup with a true shift-register implementation.
- Configurable width, taps and seed. Steps on an internal clock-enable tick instead of a derived clock.
- Adds a seed-load path, a single-step mode, period-wrap detection and a step counter.
- Sits between the board clock and the display/LED logic as the pattern source.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/tick_gen.sv | 28 ++
 rtl/lfsr_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length tap masks for widths 2..32 and the one-step update function.
package lfsr_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Bit i set means state[i] feeds the XOR; one entry per width 2..32.
  localparam logic [MAX_WIDTH-1:0] MAX_TAPS [2:32] = '{
    32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
    32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
    32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
    32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
    32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
    32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
    32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
    32'h2000_0029, 32'h4800_0000, 32'h8020_0003
  };

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0, result trimmed to width.
  function automatic logic [MAX_WIDTH-1:0] lfsr_next(
    input logic [MAX_WIDTH-1:0] state,
    input logic [MAX_WIDTH-1:0] taps,
    input int unsigned          width
  );
    logic [63:0] mask;
    logic        fb;
    mask = (64'd1 << width) - 64'd1;
    fb   = ^(state & taps);
    return ((state << 1) | MAX_WIDTH'(fb)) & MAX_WIDTH'(mask);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Single-cycle clock-enable divider: one tick every DIV enabled cycles, all on clk.
module tick_gen #(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is combinational so the step lands on the same edge the counter wraps.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Pattern source: Fibonacci LFSR stepped by a divider tick or a manual request, with load, wrap and step count.
import lfsr_pkg::*;

module lfsr_gen #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1),
  parameter int unsigned          DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             step_req,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             step_valid,
  output logic             wrap,
  output logic [WIDTH-1:0] step_cnt,
  output logic             load_err
);

  logic             tick;
  logic             step_req_d;
  logic             step;
  logic [WIDTH-1:0] next_state;

  // Divider only runs in free-run mode; single-step mode holds it at zero.
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr | mode),
    .en    (en & ~mode),
    .tick  (tick)
  );

  assign next_state = WIDTH'(lfsr_next(MAX_WIDTH'(lfsr_out), MAX_WIDTH'(TAPS), WIDTH));
  assign step       = mode ? (en & step_req & ~step_req_d) : tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_out   <= SEED;
      step_cnt   <= '0;
      step_req_d <= 1'b0;
      step_valid <= 1'b0;
      wrap       <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      wrap       <= 1'b0;
      load_err   <= 1'b0;
      if (en) begin
        step_req_d <= step_req;
      end
      if (clr) begin
        lfsr_out <= SEED;
        step_cnt <= '0;
      end else if (load) begin
        step_cnt <= '0;
        if (load_val != '0) begin
          lfsr_out <= load_val;
        end else begin
          lfsr_out <= SEED;
          load_err <= 1'b1;
        end
      end else if (en && (lfsr_out == '0)) begin
        // All-zero state would never leave; recover to SEED.
        lfsr_out <= SEED;
        step_cnt <= '0;
        load_err <= 1'b1;
      end else if (step) begin
        lfsr_out   <= next_state;
        step_valid <= 1'b1;
        if (next_state == SEED) begin
          wrap     <= 1'b1;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule
